// File: rtl/debug_unit.sv
// debug_unit: host-facing control stage for the MIPS pipeline.
//   i_rx_data/i_rx_valid : host command/data bytes (LOAD, RUN, STEP, DUMP)
//   o_imem_*             : instruction memory write port, one word per LOAD_WRITE cycle
//   o_cpu_enable         : pipeline clock enable (RUN until halt drained, single STEP cycle)
//   i_flag_halt          : halt fetched; starts a HALT_DRAIN-cycle drain
//   i_latches            : pipeline latch snapshot, streamed out with the cycle count
//   o_tx_data/o_tx_valid/i_tx_ready : byte stream to host, MSB byte first
//   o_cant_clock, o_halted : enabled-cycle count and program-finished flag
module debug_unit #(
   parameter int unsigned LEN        = 32,
   parameter int unsigned NB_DATA    = 8,
   parameter int unsigned NB_LATCHES = 453,
   parameter int unsigned HALT_DRAIN = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NB_DATA-1:0]    i_rx_data,
   input  logic                  i_rx_valid,
   output logic [NB_DATA-1:0]    o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_imem_wea,
   output logic [LEN-1:0]        o_imem_addr,
   output logic [LEN-1:0]        o_imem_data,
   output logic                  o_cpu_enable,
   input  logic                  i_flag_halt,
   input  logic [NB_LATCHES-1:0] i_latches,
   output logic [LEN-1:0]        o_cant_clock,
   output logic                  o_halted
);

   localparam int unsigned PayloadW     = ((NB_LATCHES + LEN + NB_DATA - 1) / NB_DATA) * NB_DATA;
   localparam int unsigned NBytes       = PayloadW / NB_DATA;
   localparam int unsigned TxCntW       = (NBytes > 1) ? $clog2(NBytes) : 1;
   localparam int unsigned BytesPerWord = LEN / NB_DATA;
   localparam int unsigned ByteCntW     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
   localparam int unsigned DrainW       = (HALT_DRAIN > 0) ? $clog2(HALT_DRAIN + 1) : 1;

   localparam logic [NB_DATA-1:0] CmdLoad = NB_DATA'(1);
   localparam logic [NB_DATA-1:0] CmdRun  = NB_DATA'(2);
   localparam logic [NB_DATA-1:0] CmdStep = NB_DATA'(3);
   localparam logic [NB_DATA-1:0] CmdDump = NB_DATA'(4);

   typedef enum logic [2:0] {
      StIdle, StLoadCnt, StLoadBytes, StLoadWrite, StRun, StStep, StSnap, StSend
   } state_e;

   state_e                state_q, state_d;
   logic [NB_DATA-1:0]    n_words_q, n_words_d;
   logic [LEN-1:0]        word_idx_q, word_idx_d;
   logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [LEN-1:0]        word_sr_q, word_sr_d;
   logic [LEN-1:0]        cant_q, cant_d;
   logic                  halted_q, halted_d;
   logic                  drain_act_q, drain_act_d;
   logic [DrainW-1:0]     drain_cnt_q, drain_cnt_d;
   logic [PayloadW-1:0]   payload_q, payload_d;
   logic [TxCntW-1:0]     tx_cnt_q, tx_cnt_d;
   logic                  cpu_en;
   logic                  drain_done;

   always_comb begin
      state_d     = state_q;
      n_words_d   = n_words_q;
      word_idx_d  = word_idx_q;
      byte_cnt_d  = byte_cnt_q;
      word_sr_d   = word_sr_q;
      cant_d      = cant_q;
      halted_d    = halted_q;
      drain_act_d = drain_act_q;
      drain_cnt_d = drain_cnt_q;
      payload_d   = payload_q;
      tx_cnt_d    = tx_cnt_q;
      o_imem_wea  = 1'b0;
      drain_done  = 1'b0;

      // RUN leaves as soon as the drain completes, so being in RUN/STEP means enabled.
      cpu_en = (state_q == StRun) || (state_q == StStep);

      // Halt is only observed in enabled cycles; once the drain starts it just counts.
      if (cpu_en) begin
         cant_d = cant_q + LEN'(1);
         if (!drain_act_q) begin
            if (i_flag_halt) begin
               drain_act_d = 1'b1;
               drain_cnt_d = '0;
               drain_done  = (HALT_DRAIN == 0);
            end
         end else begin
            drain_cnt_d = drain_cnt_q + DrainW'(1);
            drain_done  = (drain_cnt_d == DrainW'(HALT_DRAIN));
         end
         if (drain_done) halted_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (i_rx_valid) begin
               if (i_rx_data == CmdLoad) begin
                  halted_d    = 1'b0;
                  cant_d      = '0;
                  drain_act_d = 1'b0;
                  drain_cnt_d = '0;
                  state_d     = StLoadCnt;
               end else if (i_rx_data == CmdRun && !halted_q) begin
                  state_d = StRun;
               end else if (i_rx_data == CmdStep && !halted_q) begin
                  state_d = StStep;
               end else if (i_rx_data == CmdDump) begin
                  state_d = StSnap;
               end
            end
         end
         StLoadCnt: begin
            if (i_rx_valid) begin
               if (i_rx_data == '0) begin
                  state_d = StIdle;
               end else begin
                  n_words_d  = i_rx_data;
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  state_d    = StLoadBytes;
               end
            end
         end
         StLoadBytes: begin
            if (i_rx_valid) begin
               // Big-endian: first byte ends up in the top of the word.
               word_sr_d  = {word_sr_q[LEN-NB_DATA-1:0], i_rx_data};
               byte_cnt_d = byte_cnt_q + ByteCntW'(1);
               if (byte_cnt_q == ByteCntW'(BytesPerWord - 1)) state_d = StLoadWrite;
            end
         end
         StLoadWrite: begin
            o_imem_wea = 1'b1;
            word_idx_d = word_idx_q + LEN'(1);
            state_d    = (word_idx_d == LEN'(n_words_q)) ? StIdle : StLoadBytes;
         end
         StRun: begin
            if (drain_done) state_d = StSnap;
         end
         StStep: begin
            state_d = StSnap;
         end
         StSnap: begin
            payload_d = PayloadW'({i_latches, cant_q});
            tx_cnt_d  = '0;
            state_d   = StSend;
         end
         StSend: begin
            if (i_tx_ready) begin
               payload_d = payload_q << NB_DATA;
               tx_cnt_d  = tx_cnt_q + TxCntW'(1);
               if (tx_cnt_q == TxCntW'(NBytes - 1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= StIdle;
         n_words_q   <= '0;
         word_idx_q  <= '0;
         byte_cnt_q  <= '0;
         word_sr_q   <= '0;
         cant_q      <= '0;
         halted_q    <= 1'b0;
         drain_act_q <= 1'b0;
         drain_cnt_q <= '0;
         payload_q   <= '0;
         tx_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         n_words_q   <= n_words_d;
         word_idx_q  <= word_idx_d;
         byte_cnt_q  <= byte_cnt_d;
         word_sr_q   <= word_sr_d;
         cant_q      <= cant_d;
         halted_q    <= halted_d;
         drain_act_q <= drain_act_d;
         drain_cnt_q <= drain_cnt_d;
         payload_q   <= payload_d;
         tx_cnt_q    <= tx_cnt_d;
      end
   end

   assign o_cpu_enable = cpu_en;
   assign o_imem_addr  = word_idx_q;
   assign o_imem_data  = word_sr_q;
   assign o_tx_valid   = (state_q == StSend);
   assign o_tx_data    = payload_q[PayloadW-1 -: NB_DATA];
   assign o_cant_clock = cant_q;
   assign o_halted     = halted_q;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected imem writes and tx bytes are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_debug_unit;

   localparam int unsigned LEN        = 32;
   localparam int unsigned NB_DATA    = 8;
   localparam int unsigned NB_LATCHES = 453;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NB_DATA-1:0]    rx_data = '0;
   logic                  rx_valid = 1'b0;
   logic [NB_DATA-1:0]    tx_data;
   logic                  tx_valid;
   logic                  tx_ready = 1'b0;
   logic                  wea;
   logic [LEN-1:0]        addr;
   logic [LEN-1:0]        wdata;
   logic                  cpu_en;
   logic                  flag_halt = 1'b0;
   logic [NB_LATCHES-1:0] latches;
   logic [LEN-1:0]        cant;
   logic                  halted;

   int errors = 0;
   int checks = 0;
   int en_cnt = 0;
   int wr_cnt = 0;
   int tx_cnt = 0;
   logic [63:0] exp_wr_q[$];
   logic [7:0]  exp_tx_q[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = '0;

   debug_unit #(
      .LEN(LEN), .NB_DATA(NB_DATA), .NB_LATCHES(NB_LATCHES), .HALT_DRAIN(4)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_imem_wea(wea), .o_imem_addr(addr), .o_imem_data(wdata),
      .o_cpu_enable(cpu_en), .i_flag_halt(flag_halt), .i_latches(latches),
      .o_cant_clock(cant), .o_halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [487:0] payload(input logic [31:0] c);
      return {3'b000, latches, c};
   endfunction

   task automatic push_dump(input logic [31:0] c);
      logic [487:0] p;
      p = payload(c);
      for (int i = 60; i >= 0; i--) exp_tx_q.push_back(p[i*8 +: 8]);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (cpu_en) en_cnt <= en_cnt + 1;
         if (wea) begin
            wr_cnt <= wr_cnt + 1;
            if (exp_wr_q.size() == 0) check_eq("wr_unexpected", 64'(wea), 64'd0);
            else check_eq("imem_wr", {addr, wdata}, exp_wr_q.pop_front());
         end
         if (prev_stall) check_eq("tx_stable", 64'(tx_data), 64'(prev_data));
         if (tx_valid && tx_ready) begin
            tx_cnt <= tx_cnt + 1;
            if (exp_tx_q.size() == 0) check_eq("tx_unexpected", 64'(tx_valid), 64'd0);
            else check_eq("tx_byte", 64'(tx_data), 64'(exp_tx_q.pop_front()));
         end
         prev_stall <= tx_valid && !tx_ready;
         prev_data  <= tx_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(2);
   endtask

   task automatic wait_tx_done(input bit toggle);
      for (int i = 0; i < 3000 && exp_tx_q.size() != 0; i++) begin
         if (toggle) tx_ready = (i % 3 == 0);
         tick(1);
      end
      check_eq("tx_drained", 64'(exp_tx_q.size()), 64'd0);
      exp_tx_q.delete();
      tx_ready = 1'b1;
      tick(3);
   endtask

   task automatic check_all_zero();
      check_eq("rst_wea", 64'(wea), 64'd0);
      check_eq("rst_addr", 64'(addr), 64'd0);
      check_eq("rst_data", 64'(wdata), 64'd0);
      check_eq("rst_en", 64'(cpu_en), 64'd0);
      check_eq("rst_txv", 64'(tx_valid), 64'd0);
      check_eq("rst_txd", 64'(tx_data), 64'd0);
      check_eq("rst_cant", 64'(cant), 64'd0);
      check_eq("rst_halted", 64'(halted), 64'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3;
      rst      = 1'b0;
      rx_valid = 1'b0;
      #1;
      check_all_zero();
      tick(2);
      rst = 1'b1;
      tick(2);
   endtask

   initial begin
      logic [479:0] tmp;
      int           e0;
      int           w0;
      int           t0;
      for (int i = 0; i < 15; i++) tmp[i*32 +: 32] = $urandom;
      latches = tmp[NB_LATCHES-1:0];

      // Reset state
      #2;
      check_all_zero();
      tick(2);
      rst = 1'b1;
      tick(2);

      // LOAD two words
      exp_wr_q.push_back({32'd0, 32'h1234_5678});
      exp_wr_q.push_back({32'd1, 32'hABCD_EF01});
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
      tick(4);
      check_eq("load_wr_cnt", 64'(wr_cnt), 64'd2);
      check_eq("load_wr_left", 64'(exp_wr_q.size()), 64'd0);

      // RUN, halt seen at the 10th enabled cycle
      tx_ready = 1'b1;
      en_cnt   = 0;
      push_dump(32'd14);
      rx_data  = 8'h02;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      for (int i = 0; i < 100 && en_cnt < 9; i++) tick(1);
      flag_halt = 1'b1;
      wait_tx_done(1'b0);
      check_eq("run_en_cycles", 64'(en_cnt), 64'd14);
      check_eq("run_halted", 64'(halted), 64'd1);
      check_eq("run_cant", 64'(cant), 64'd14);

      // RUN/STEP ignored while halted
      e0 = en_cnt;
      t0 = tx_cnt;
      send_byte(8'h02);
      send_byte(8'h03);
      tick(20);
      check_eq("halt_no_en", 64'(en_cnt - e0), 64'd0);
      check_eq("halt_no_tx", 64'(tx_cnt - t0), 64'd0);
      check_eq("halt_still", 64'(halted), 64'd1);
      flag_halt = 1'b0;

      // LOAD with N=0 clears halt and count
      w0 = wr_cnt;
      send_byte(8'h01);
      send_byte(8'h00);
      tick(3);
      check_eq("n0_halted", 64'(halted), 64'd0);
      check_eq("n0_cant", 64'(cant), 64'd0);
      check_eq("n0_no_wr", 64'(wr_cnt - w0), 64'd0);

      // STEP x3
      for (int k = 1; k <= 3; k++) begin
         e0 = en_cnt;
         push_dump(32'(k));
         send_byte(8'h03);
         wait_tx_done(1'b0);
         check_eq("step_en", 64'(en_cnt - e0), 64'd1);
         check_eq("step_cant", 64'(cant), 64'(k));
      end

      // DUMP with ready 1 of 3 cycles
      e0 = en_cnt;
      t0 = tx_cnt;
      tx_ready = 1'b0;
      push_dump(32'd3);
      send_byte(8'h04);
      wait_tx_done(1'b1);
      check_eq("dump_bytes", 64'(tx_cnt - t0), 64'd61);
      check_eq("dump_no_en", 64'(en_cnt - e0), 64'd0);

      // Reset mid-LOAD after two word bytes
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'hDE);
      send_byte(8'hAD);
      pulse_reset();

      // Reset mid-SEND while the host is stalling
      tx_ready = 1'b0;
      begin
         logic [487:0] p;
         p = payload(32'd0);
         send_byte(8'h04);
         tick(2);
         check_eq("send_valid", 64'(tx_valid), 64'd1);
         check_eq("send_first", 64'(tx_data), 64'(p[487:480]));
      end
      pulse_reset();
      tx_ready = 1'b1;

      // LOAD after reset writes word 0 cleanly
      w0 = wr_cnt;
      exp_wr_q.push_back({32'd0, 32'hCAFE_F00D});
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
      tick(4);
      check_eq("post_rst_wr_cnt", 64'(wr_cnt - w0), 64'd1);
      check_eq("post_rst_wr_left", 64'(exp_wr_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
